wb_cmd_master: RTL and testbench

//   Single-outstanding Wishbone classic initiator. It turns one command from a

---
 rtl/wb_cmd_master.sv | 166 ++++++++++++++++
 tb/tb_wb_cmd_master.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone classic initiator.
// One command on the valid/ready command port becomes one Wishbone cycle.
// The result is then returned on the valid/ready response port.
// Optional ack timeout: define WB_CMD_MASTER_TIMEOUT_EN to build the abort counter.
// Without the macro, BUS waits for an ack indefinitely and rsp_err stays 0.
module wb_cmd_master #(
  parameter int TO_W           = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**TO_W) - 1) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES must lie in 1..2**TO_W-1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        cmd_ready_d;
  logic        cyc_d;
  logic        we_d;
  logic [31:0] adr_d;
  logic [31:0] dat_d;
  logic [3:0]  sel_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_dat_d;
  logic        rsp_err_d;
  logic        timeout_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Count un-acked BUS cycles; held at zero outside BUS so every cycle starts fresh
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt <= '0;
    end else if (state_q != BUS) begin
      to_cnt <= '0;
    end else if (!m_ack_i) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // The abort edge is the one that would bring the count up to TIMEOUT_CYCLES
  assign timeout_hit = (state_q == BUS) && !m_ack_i &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register plus the registered copies of every output
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b1;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      m_sel_o   <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      m_cyc_o   <= cyc_d;
      m_stb_o   <= cyc_d;
      m_we_o    <= we_d;
      m_adr_o   <= adr_d;
      m_dat_o   <= dat_d;
      m_sel_o   <= sel_d;
      rsp_valid <= rsp_valid_d;
      rsp_dat   <= rsp_dat_d;
      rsp_err   <= rsp_err_d;
    end
  end

  // Next-state selection: one Wishbone cycle per command, then one response handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) state_d = BUS;
      BUS:  if (m_ack_i || timeout_hit) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; anything not updated holds its value
  always_comb begin
    cmd_ready_d = cmd_ready;
    cyc_d       = m_cyc_o;
    we_d        = m_we_o;
    adr_d       = m_adr_o;
    dat_d       = m_dat_o;
    sel_d       = m_sel_o;
    rsp_valid_d = rsp_valid;
    rsp_dat_d   = rsp_dat;
    rsp_err_d   = rsp_err;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          we_d        = cmd_we;
          adr_d       = cmd_adr;
          dat_d       = cmd_dat;
          sel_d       = cmd_sel;
        end
      end
      BUS: begin
        if (m_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = m_we_o ? 32'h0000_0000 : m_dat_i;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = 32'hFFFF_FFFF;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master.
// Table-driven transactions plus hand-written sequences for response back-pressure,
// timeout, asynchronous reset and stray acks. Responses are checked against a scoreboard.
module tb_wb_cmd_master;

  localparam int TO_CYC = 4;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  logic        resp_ack;
  logic        stray_ack;
  int          resp_wait;
  logic [31:0] resp_data;
  int          stb_cnt;

  int          errors;
  int          checks;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_wait;
    logic [31:0] rdata;
    logic [31:0] exp_dat;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  vec_t vecs[5];
  rsp_t sb_q[$];

  assign m_ack_i = resp_ack | stray_ack;

  wb_cmd_master #(
    .TO_W          (8),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_we_o   (m_we_o),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_sel_o  (m_sel_o),
    .m_dat_i  (m_dat_i),
    .m_ack_i  (m_ack_i)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs despite the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Responder: acks in the (resp_wait+1)-th STB cycle; resp_wait < 0 means never ack
  always @(negedge clk) begin
    if (m_cyc_o && m_stb_o && resp_wait >= 0) begin
      if (stb_cnt == resp_wait) begin
        resp_ack = 1'b1;
        m_dat_i  = resp_data;
      end else begin
        resp_ack = 1'b0;
      end
      stb_cnt++;
    end else begin
      resp_ack = 1'b0;
      stb_cnt  = 0;
    end
  end

  // Scoreboard: every response handshake is compared with the oldest expected entry
  always @(negedge clk) begin : monitor
    rsp_t exp_r;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got rsp_dat 0x%08h, expected no response", rsp_dat);
      end else begin
        exp_r = sb_q.pop_front();
        checkOutput("rsp_dat", rsp_dat, exp_r.dat);
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_r.err));
      end
    end
  end

  task automatic driveCmd(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
  endtask

  task automatic scrambleCmd();
    cmd_valid = 1'b0;
    cmd_we    = ~cmd_we;
    cmd_adr   = 32'h0BAD_0BAD;
    cmd_dat   = 32'h5A5A_5A5A;
    cmd_sel   = 4'h0;
  endtask

  task automatic waitAccept(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (m_cyc_o) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({name, "_accepted"}, 32'(ok), 32'd1);
  endtask

  task automatic waitIdle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (cmd_ready && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({name, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int    cyc_cnt;
    string tag;
    tag       = $sformatf("vec%0d", idx);
    resp_wait = v.ack_wait;
    resp_data = v.rdata;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    driveCmd(v.we, v.adr, v.dat, v.sel);
    sb_q.push_back('{dat: v.exp_dat, err: 1'b0});
    waitAccept(tag);
    scrambleCmd();
    checkOutput({tag, "_m_we"},  32'(m_we_o), 32'(v.we));
    checkOutput({tag, "_m_adr"}, m_adr_o, v.adr);
    checkOutput({tag, "_m_dat"}, m_dat_o, v.dat);
    checkOutput({tag, "_m_sel"}, 32'(m_sel_o), 32'(v.sel));
    checkOutput({tag, "_m_stb"}, 32'(m_stb_o), 32'd1);
    cyc_cnt = 1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (!m_cyc_o) break;
      cyc_cnt++;
    end
    checkOutput({tag, "_cyc_cycles"}, 32'(cyc_cnt), 32'(v.exp_cyc));
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_adr_hold"}, m_adr_o, v.adr);
    @(posedge clk); #1;
    checkOutput({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held_dat;
    bit          stable;
    int          cyc_cnt;

    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    m_dat_i   = '0;
    resp_ack  = 1'b0;
    stray_ack = 1'b0;
    resp_wait = -1;
    resp_data = '0;
    stb_cnt   = 0;

    vecs[0] = '{we: 1'b1, adr: 32'h3000_0004, dat: 32'hA5A5_1234, sel: 4'hF, ack_wait: 0,
                rdata: 32'h1111_1111, exp_dat: 32'h0000_0000, exp_cyc: 1};
    vecs[1] = '{we: 1'b0, adr: 32'h3000_0000, dat: 32'h0000_0000, sel: 4'hF, ack_wait: 3,
                rdata: 32'hDEAD_0001, exp_dat: 32'hDEAD_0001, exp_cyc: 4};
    vecs[2] = '{we: 1'b0, adr: 32'h3000_0010, dat: 32'hFFFF_0000, sel: 4'h3, ack_wait: 0,
                rdata: 32'h1234_5678, exp_dat: 32'h1234_5678, exp_cyc: 1};
    vecs[3] = '{we: 1'b1, adr: 32'h3000_00FC, dat: 32'h0F0F_F0F0, sel: 4'h5, ack_wait: 2,
                rdata: 32'hCAFE_CAFE, exp_dat: 32'h0000_0000, exp_cyc: 3};
    vecs[4] = '{we: 1'b0, adr: 32'h0000_0000, dat: 32'h8765_4321, sel: 4'h8, ack_wait: 1,
                rdata: 32'h0000_0000, exp_dat: 32'h0000_0000, exp_cyc: 2};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_cyc", 32'(m_cyc_o), 32'd0);
    checkOutput("reset_stb", 32'(m_stb_o), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_dat", rsp_dat, 32'd0);
    checkOutput("reset_adr", m_adr_o, 32'd0);
    #2 rst = 1'b0;

    // Table-driven transactions
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Response held by back-pressure, with a pending command waiting
    $display("[TB] back-pressure sequence");
    rsp_ready = 1'b0;
    resp_wait = 0;
    resp_data = 32'h5555_AAAA;
    @(posedge clk); #1;
    driveCmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    sb_q.push_back('{dat: 32'h5555_AAAA, err: 1'b0});
    waitAccept("bp_first");
    scrambleCmd();
    @(posedge clk); #1;
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    driveCmd(1'b1, 32'h3000_0024, 32'h1357_9BDF, 4'hC);
    sb_q.push_back('{dat: 32'h0000_0000, err: 1'b0});
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'h5555_AAAA || cmd_ready !== 1'b0 || m_cyc_o !== 1'b0)
        stable = 1'b0;
    end
    checkOutput("bp_hold_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_consumed_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_consumed_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("bp_not_same_cycle", 32'(m_cyc_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("bp_pending_accepted", 32'(m_cyc_o), 32'd1);
    checkOutput("bp_pending_adr", m_adr_o, 32'h3000_0024);
    scrambleCmd();
    waitIdle("bp");

    // Responder that never acks
    $display("[TB] no-ack sequence");
    resp_wait = -1;
    resp_data = 32'h0000_BEEF;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    driveCmd(1'b0, 32'h3000_0030, 32'h0, 4'hF);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    sb_q.push_back('{dat: 32'hFFFF_FFFF, err: 1'b1});
    waitAccept("to");
    scrambleCmd();
    cyc_cnt = 1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (!m_cyc_o) break;
      cyc_cnt++;
    end
    checkOutput("to_cyc_cycles", 32'(cyc_cnt), 32'(TO_CYC));
    checkOutput("to_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("to_rsp_err", 32'(rsp_err), 32'd1);
    waitIdle("to");
`else
    waitAccept("noto");
    scrambleCmd();
    repeat (300) @(posedge clk);
    #1;
    checkOutput("noto_cyc_held", 32'(m_cyc_o), 32'd1);
    checkOutput("noto_stb_held", 32'(m_stb_o), 32'd1);
    checkOutput("noto_no_rsp", 32'(rsp_valid), 32'd0);
    resp_wait = 0;
    sb_q.push_back('{dat: 32'h0000_BEEF, err: 1'b0});
    waitIdle("noto");
`endif

    // Asynchronous reset in the middle of a bus cycle
    $display("[TB] mid-bus reset sequence");
    resp_wait = -1;
    @(posedge clk); #1;
    driveCmd(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    waitAccept("rst");
    scrambleCmd();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_async_cyc", 32'(m_cyc_o), 32'd0);
    checkOutput("rst_async_stb", 32'(m_stb_o), 32'd0);
    checkOutput("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_async_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_async_adr", m_adr_o, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    resp_wait = 0;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || m_cyc_o !== 1'b0) stable = 1'b0;
    end
    checkOutput("rst_no_stale_rsp", 32'(stable), 32'd1);

    // Stray acks while idle
    $display("[TB] stray-ack sequence");
    @(posedge clk); #1;
    stray_ack = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (m_cyc_o !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) stable = 1'b0;
    end
    stray_ack = 1'b0;
    checkOutput("stray_idle_no_change", 32'(stable), 32'd1);

    // Stray acks while a response is waiting
    rsp_ready = 1'b0;
    resp_wait = 0;
    resp_data = 32'h7777_0007;
    @(posedge clk); #1;
    driveCmd(1'b0, 32'h3000_0050, 32'h0, 4'hF);
    sb_q.push_back('{dat: 32'h7777_0007, err: 1'b0});
    waitAccept("stray_resp");
    scrambleCmd();
    @(posedge clk); #1;
    held_dat  = rsp_dat;
    checkOutput("stray_resp_dat_first", held_dat, 32'h7777_0007);
    stray_ack = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'h7777_0007 || cmd_ready !== 1'b0 ||
          m_cyc_o !== 1'b0 || rsp_err !== 1'b0) stable = 1'b0;
    end
    stray_ack = 1'b0;
    checkOutput("stray_resp_no_change", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    waitIdle("stray_resp");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
